// File: rtl/nios_irq_pkg.sv
// Shared register map, field positions and helpers for the Nios II interrupt aggregator.
package nios_irq_pkg;

   localparam int DATA_W           = 16;
   localparam int ADDR_W           = 3;
   localparam int ACTIVE_VALID_BIT = 15;
   localparam int IRQ_ID_W         = 4;

   typedef logic [DATA_W-1:0]   avl_data_t;
   typedef logic [ADDR_W-1:0]   avl_addr_t;
   typedef logic [IRQ_ID_W-1:0] irq_id_t;

   localparam avl_addr_t ADDR_PENDING = 3'd0;
   localparam avl_addr_t ADDR_ENABLE  = 3'd1;
   localparam avl_addr_t ADDR_EDGE    = 3'd2;
   localparam avl_addr_t ADDR_CLEAR   = 3'd3;
   localparam avl_addr_t ADDR_ACTIVE  = 3'd4;
   localparam avl_addr_t ADDR_SWSET   = 3'd5;

   // Packs the ACTIVE register word: valid flag on top, id in the low nibble.
   function automatic avl_data_t active_word(input logic valid, input irq_id_t id);
      avl_data_t w;
      w = '0;
      w[ACTIVE_VALID_BIT] = valid;
      w[IRQ_ID_W-1:0]     = id;
      return w;
   endfunction

endpackage

// File: rtl/irq_prio_encoder.sv
// Combinational priority encoder: reports the lowest set index of req.
module irq_prio_encoder
   import nios_irq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]        req,
   output logic                valid,
   output logic [IRQ_ID_W-1:0] id
);

   // Scanning from the top down lets the lowest index overwrite last.
   always_comb begin
      valid = 1'b0;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = IRQ_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/nios_irq_aggregator.sv
// Avalon-MM interrupt aggregator: latches/samples peripheral irq lines, masks them,
// and drives one registered irq to the Nios II CPU plus a highest-priority id.
module nios_irq_aggregator
   import nios_irq_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq_out
);

   // Bus: a write is accepted in the cycle chipselect & ~write_n is seen (no wait-states);
   // readdata always reflects the addressed register one clk after address is presented.

   logic [NUM_IRQ-1:0]  irq_s;
   logic [NUM_IRQ-1:0]  irq_s_d;
   logic [NUM_IRQ-1:0]  enable_q;
   logic [NUM_IRQ-1:0]  edge_q;
   logic [NUM_IRQ-1:0]  latched_q;
   logic [NUM_IRQ-1:0]  wd;
   logic [NUM_IRQ-1:0]  set_vec;
   logic [NUM_IRQ-1:0]  clr_vec;
   logic [NUM_IRQ-1:0]  pending;
   logic [NUM_IRQ-1:0]  masked;
   logic                wr_any;
   logic                wr_enable;
   logic                wr_edge;
   logic                wr_clear;
   logic                wr_swset;
   logic                act_valid;
   logic [IRQ_ID_W-1:0] act_id;
   avl_data_t           pend_ext;
   avl_data_t           enable_ext;
   avl_data_t           edge_ext;
   avl_data_t           masked_ext;
   avl_data_t           read_mux;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = irq_in;
   end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         end
      end
      assign irq_s = sync_q[SYNC_STAGES-1];
   end

   if (NUM_IRQ < DATA_W) begin : g_wd_unused
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[DATA_W-1:NUM_IRQ];
   end

   assign wd        = writedata[NUM_IRQ-1:0];
   assign wr_any    = chipselect & ~write_n;
   assign wr_enable = wr_any & (address == ADDR_ENABLE);
   assign wr_edge   = wr_any & (address == ADDR_EDGE);
   assign wr_clear  = wr_any & (address == ADDR_CLEAR);
   assign wr_swset  = wr_any & (address == ADDR_SWSET);

   // Set beats clear so an edge arriving with a CLEAR write is never lost.
   assign set_vec = (edge_q & irq_s & ~irq_s_d) | (wr_swset ? wd : '0);
   assign clr_vec = wr_clear ? wd : '0;
   assign pending = latched_q | (~edge_q & irq_s);
   assign masked  = pending & enable_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_s_d   <= '0;
         enable_q  <= '0;
         edge_q    <= '0;
         latched_q <= '0;
         irq_out   <= 1'b0;
         readdata  <= '0;
      end else begin
         irq_s_d   <= irq_s;
         latched_q <= set_vec | (latched_q & ~clr_vec);
         if (wr_enable) enable_q <= wd;
         if (wr_edge)   edge_q   <= wd;
         irq_out   <= |masked;
         readdata  <= read_mux;
      end
   end

   irq_prio_encoder #(.N(NUM_IRQ)) u_prio (
      .req   (masked),
      .valid (act_valid),
      .id    (act_id)
   );

   always_comb begin
      pend_ext   = '0;
      enable_ext = '0;
      edge_ext   = '0;
      masked_ext = '0;
      pend_ext[NUM_IRQ-1:0]   = pending;
      enable_ext[NUM_IRQ-1:0] = enable_q;
      edge_ext[NUM_IRQ-1:0]   = edge_q;
      masked_ext[NUM_IRQ-1:0] = masked;
      case (address)
         ADDR_PENDING: read_mux = pend_ext;
         ADDR_ENABLE:  read_mux = enable_ext;
         ADDR_EDGE:    read_mux = edge_ext;
         ADDR_CLEAR:   read_mux = masked_ext;
         ADDR_ACTIVE:  read_mux = active_word(act_valid, act_id);
         default:      read_mux = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_irq_aggregator.sv
// Directed bench for nios_irq_aggregator (NUM_IRQ=8, SYNC_STAGES=0).
module tb_nios_irq_aggregator;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [7:0]  irq_in;
   logic        irq_out;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   nios_irq_aggregator #(.NUM_IRQ(8), .SYNC_STAGES(0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq_out    (irq_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      logic [15:0] e;
      exp_q.push_back(exp);
      e = exp_q.pop_front();
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string tag);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(negedge clk);
      check(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic check_irq(input string tag, input logic exp);
      check(tag, {15'd0, irq_out}, {15'd0, exp});
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      irq_in     = '0;
      tick(2);
      reset_n = 1'b1;
      tick(1);

      // T1 reset / idle
      check("t1_readdata", readdata, 16'h0000);
      check_irq("t1_irq", 1'b0);
      for (int a = 0; a < 8; a++) bus_read(3'(a), 16'h0000, $sformatf("t1_read%0d", a));

      // T2 edge source 0
      bus_write(3'd2, 16'h0001);
      bus_write(3'd1, 16'h0001);
      irq_in[0] = 1'b1;
      tick(1);
      irq_in[0] = 1'b0;
      check_irq("t2_irq_clk1", 1'b0);
      tick(1);
      check_irq("t2_irq_clk2", 1'b1);
      bus_read(3'd0, 16'h0001, "t2_pending");
      bus_read(3'd4, 16'h8000, "t2_active");
      bus_write(3'd3, 16'h0001);
      tick(1);
      check_irq("t2_irq_cleared", 1'b0);
      bus_read(3'd0, 16'h0000, "t2_pending_cleared");

      // T3 level source 2
      bus_write(3'd2, 16'h0000);
      bus_write(3'd1, 16'h0004);
      irq_in[2] = 1'b1;
      tick(1);
      check_irq("t3_irq_level", 1'b1);
      bus_write(3'd3, 16'h0004);
      bus_read(3'd0, 16'h0004, "t3_pending_held");
      check_irq("t3_irq_held", 1'b1);
      irq_in[2] = 1'b0;
      tick(1);
      check_irq("t3_irq_drop", 1'b0);

      // T4 priority and upper writedata bits ignored
      bus_write(3'd1, 16'hFFFF);
      bus_read(3'd1, 16'h00FF, "t4_enable_width");
      bus_write(3'd5, 16'h0028);
      bus_read(3'd0, 16'h0028, "t4_pending");
      bus_read(3'd4, 16'h8003, "t4_active_3");
      bus_read(3'd3, 16'h0028, "t4_clear_read");
      bus_write(3'd3, 16'h0008);
      bus_read(3'd4, 16'h8005, "t4_active_5");
      bus_write(3'd3, 16'h0020);
      bus_read(3'd4, 16'h0000, "t4_active_none");
      check_irq("t4_irq_none", 1'b0);

      // T5 mask then unmask; switching a high line to edge mode makes no edge
      bus_write(3'd1, 16'h0000);
      irq_in[4] = 1'b1;
      tick(1);
      bus_read(3'd0, 16'h0010, "t5_level_src4");
      bus_write(3'd2, 16'h0012);
      tick(2);
      irq_in[1] = 1'b1;
      tick(1);
      irq_in[1] = 1'b0;
      irq_in[4] = 1'b0;
      tick(2);
      check_irq("t5_irq_masked", 1'b0);
      bus_read(3'd0, 16'h0002, "t5_pending_masked");
      bus_write(3'd1, 16'h0002);
      tick(1);
      check_irq("t5_irq_unmasked", 1'b1);
      bus_read(3'd4, 16'h8001, "t5_active");
      bus_write(3'd3, 16'h0002);

      // T6 set beats clear, then asynchronous reset
      bus_write(3'd2, 16'h0001);
      bus_write(3'd1, 16'h0001);
      tick(1);
      irq_in[0]  = 1'b1;
      address    = 3'd3;
      writedata  = 16'h0001;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      bus_read(3'd0, 16'h0001, "t6_set_wins");
      check_irq("t6_irq", 1'b1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_readdata", readdata, 16'h0000);
      check_irq("t6_rst_irq", 1'b0);
      irq_in = '0;
      @(negedge clk);
      reset_n = 1'b1;
      tick(1);
      bus_read(3'd0, 16'h0000, "t6_post_pending");
      bus_read(3'd1, 16'h0000, "t6_post_enable");
      bus_read(3'd2, 16'h0000, "t6_post_edge");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
